// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: the blank pattern, the 16 hex glyphs
// (active-low {g,f,e,d,c,b,a}) and the scan FSM state type.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] GLYPH_0 = 7'b1000000;
   localparam logic [6:0] GLYPH_1 = 7'b1111001;
   localparam logic [6:0] GLYPH_2 = 7'b0100100;
   localparam logic [6:0] GLYPH_3 = 7'b0110000;
   localparam logic [6:0] GLYPH_4 = 7'b0011001;
   localparam logic [6:0] GLYPH_5 = 7'b0010010;
   localparam logic [6:0] GLYPH_6 = 7'b0000010;
   localparam logic [6:0] GLYPH_7 = 7'b1111000;
   localparam logic [6:0] GLYPH_8 = 7'b0000000;
   localparam logic [6:0] GLYPH_9 = 7'b0010000;
   localparam logic [6:0] GLYPH_A = 7'b0001000;
   localparam logic [6:0] GLYPH_B = 7'b0000011;
   localparam logic [6:0] GLYPH_C = 7'b1000110;
   localparam logic [6:0] GLYPH_D = 7'b0100001;
   localparam logic [6:0] GLYPH_E = 7'b0000110;
   localparam logic [6:0] GLYPH_F = 7'b0001110;

   typedef enum logic {
      DRIVE = 1'b0,
      BLANK = 1'b1
   } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_OFF;
      case (nibble)
         4'h0: seg_n = GLYPH_0;
         4'h1: seg_n = GLYPH_1;
         4'h2: seg_n = GLYPH_2;
         4'h3: seg_n = GLYPH_3;
         4'h4: seg_n = GLYPH_4;
         4'h5: seg_n = GLYPH_5;
         4'h6: seg_n = GLYPH_6;
         4'h7: seg_n = GLYPH_7;
         4'h8: seg_n = GLYPH_8;
         4'h9: seg_n = GLYPH_9;
         4'hA: seg_n = GLYPH_A;
         4'hB: seg_n = GLYPH_B;
         4'hC: seg_n = GLYPH_C;
         4'hD: seg_n = GLYPH_D;
         4'hE: seg_n = GLYPH_E;
         4'hF: seg_n = GLYPH_F;
         default: seg_n = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan driver advanced by rising edges of tick_in, with a one-cycle
// anode-off gap per digit. Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter  int NUM_DIGITS = 4,
   localparam int DATA_W     = 4 * NUM_DIGITS
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  tick_in,
   input  logic [DATA_W-1:0]     data_in,
   input  logic [NUM_DIGITS-1:0] dp_in,
   input  logic                  blank_all,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int              SEL_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

   scan_state_t             state_q, state_d;
   logic                    tick_q, step;
   logic [SEL_W-1:0]        dig_sel, sel_d, adv_sel;
   logic [DATA_W-1:0]       shadow_data, shadow_data_d, adv_data;
   logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_d, adv_dp;
   logic                    load_pend, load_pend_d;
   logic [NUM_DIGITS-1:0]   an_d, cur_an, lz_cur, lz_adv;
   logic [6:0]              seg_d, adv_glyph;
   logic [3:0]              adv_nib;
   logic                    dp_d;

   assign step = tick_in & ~tick_q;

   // The digit a step moves to, and the frame it will show: a wrap to digit 0 takes data_in.
   assign adv_sel  = (dig_sel == LAST_SEL) ? '0 : dig_sel + 1'b1;
   assign adv_data = (dig_sel == LAST_SEL) ? data_in : shadow_data;
   assign adv_dp   = (dig_sel == LAST_SEL) ? dp_in : shadow_dp;
   assign adv_nib  = adv_data[{adv_sel, 2'b00} +: 4];

   hex_to_seg7 u_hex (
      .nibble (adv_nib),
      .seg_n  (adv_glyph)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Digit k is a leading zero when it and every digit above it is zero and its dp is off.
   always_comb begin
      lz_cur = '0;
      lz_adv = '0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         lz_cur[k] = ((shadow_data >> (4 * k)) == '0) && !shadow_dp[k];
         lz_adv[k] = ((adv_data >> (4 * k)) == '0) && !adv_dp[k];
      end
   end
`else
   assign lz_cur = '0;
   assign lz_adv = '0;
`endif

   assign cur_an = lz_cur[dig_sel] ? '1 : ~(NUM_DIGITS'(1) << dig_sel);

   always_comb begin
      state_d       = state_q;
      sel_d         = dig_sel;
      shadow_data_d = shadow_data;
      shadow_dp_d   = shadow_dp;
      load_pend_d   = load_pend;
      an_d          = an;
      seg_d         = seg;
      dp_d          = dp;
      case (state_q)
         DRIVE: begin
            if (step) begin
               sel_d         = adv_sel;
               shadow_data_d = adv_data;
               shadow_dp_d   = adv_dp;
               an_d          = '1;
               seg_d         = lz_adv[adv_sel] ? SEG_OFF : adv_glyph;
               dp_d          = ~adv_dp[adv_sel];
               state_d       = BLANK;
            end else begin
               an_d = blank_all ? '1 : cur_an;
            end
         end
         BLANK: begin
            // Steps seen here are dropped; the first gap after reset also latches a frame.
            an_d = blank_all ? '1 : cur_an;
            if (load_pend) begin
               shadow_data_d = data_in;
               shadow_dp_d   = dp_in;
               load_pend_d   = 1'b0;
            end
            state_d = DRIVE;
         end
         default: state_d = BLANK;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         tick_q      <= 1'b0;
         state_q     <= BLANK;
         dig_sel     <= '0;
         an          <= '1;
         seg         <= SEG_OFF;
         dp          <= 1'b1;
         shadow_data <= '0;
         shadow_dp   <= '0;
         load_pend   <= 1'b1;
      end else begin
         tick_q      <= tick_in;
         state_q     <= state_d;
         dig_sel     <= sel_d;
         an          <= an_d;
         seg         <= seg_d;
         dp          <= dp_d;
         shadow_data <= shadow_data_d;
         shadow_dp   <= shadow_dp_d;
         load_pend   <= load_pend_d;
      end
   end

endmodule
